aes_key_expand_iter: RTL and testbench
======================================

Name: aes_key_expand_iter

Overview:
- Iterative, parametrised successor to the combinational AES-128 key expander.
- Supports AES-128, AES-192 and AES-256, selected per run by a mode input.
- Generates one 32-bit schedule word per clock using four shared S-box lookups, then streams each 128-bit round key over a valid/ready interface.
- Feeds the encrypt datapath's add_round_key stage, replacing the flat 1408-bit key array.

Parameters:
- KEY_W, 256: width of key_in; must be 256, since words beyond Nk are ignored.
- RKIDX_W, 4: width of the round index output; covers 0..14.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin expansion; sampled only in IDLE.
- mode  in  2  key size: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = reserved.
- key_in  in  KEY_W  cipher key. Word w0 = key_in[255:224], w1 = key_in[223:192], and so on. AES-128 uses [255:128]; AES-192 uses [255:64].
- abort  in  1  synchronous cancel.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the final round key is accepted.
- err  out  1  one-cycle pulse when start is given with mode = 11.
- rk_valid  out  1  round key available.
- rk_ready  in  1  consumer accepts the round key.
- rk_data  out  128  round key. w[4r] is in [127:96]; w[4r+3] is in [31:0].
- rk_round  out  RKIDX_W  round index r of rk_data.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE.
  - busy, done, err, rk_valid = 0.
  - rk_data = 0, rk_round = 0.
  - All internal words and counters cleared.
- Derived constants from mode (Nk, Nr):
  - AES-128: Nk = 4, Nr = 10.
  - AES-192: Nk = 6, Nr = 12.
  - AES-256: Nk = 8, Nr = 14.
  - Total words = 4*(Nr+1), i.e. 44 / 52 / 60.
- States: IDLE, LOAD, GEN, DRAIN.
- IDLE:
  - start with a valid mode: latch mode and key_in, set word index i = 0, busy = 1, go to LOAD.
  - start with mode = 11: pulse err, stay in IDLE.
- Word index i = 0..Nk-1 (LOAD): emit key word w[i], one per cycle. After w[Nk-1], go to GEN.
- Word index i >= Nk (GEN): w[i] = w[i-Nk] ^ t, where t is:
  - SubWord(RotWord(w[i-1])) ^ Rcon[i/Nk] when i mod Nk = 0;
  - SubWord(w[i-1]) when Nk = 8 and i mod Nk = 4;
  - w[i-1] otherwise.
- Rcon[j] = {rc_j, 24'h0}, with rc = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- History: a shift window of the last 8 words supplies w[i-Nk]; the Nk mux selects the tap.
- Assembly: each word shifts into a 4-word assembly register. When 4 words are present, they transfer to the output register if it is empty, or is emptying this cycle (rk_valid & rk_ready). rk_round increments per transfer.
- Stall: if the assembly register is full and the output register is held, word generation stalls. i does not advance and no word is lost or duplicated.
- Handshake:
  - rk_valid stays high and rk_data/rk_round stay stable until rk_ready.
  - rk_valid & rk_ready is the transfer.
  - Back-to-back transfers sustain one round key every 4 cycles.
- Latency with rk_ready = 1: start is accepted at cycle 0, w[i] is produced at cycle i+1, and round key r is valid at cycle 4r+4. AES-128: round 10 valid at cycle 44.
- DRAIN: entered after the last word. The final round key's transfer returns the block to IDLE, pulses done, and clears busy.
- abort (any state): next cycle IDLE, rk_valid = 0, busy = 0, no done pulse. abort has priority over start in the same cycle.
- Not affected by runtime input changes:
  - start while busy: ignored.
  - key_in/mode changes while busy: no effect, since both are latched.
- Async reset mid-run: immediate return to reset values.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready = 1:
  - r0 = key; r1 = a0fafe1788542cb123a339392a6c7605; r10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - r10 valid at cycle 44; done at cycle 45.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: r12 = e98ba06f448c773c8ecc720401002202, rk_round = 12, 13 transfers total.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - r1 = 1f352c073b6108d72d9810a30914dff4;
  - r14 = fe4890d1e6188d0b046df344706c631e.
- AES-128 with random rk_ready (about 30% duty): the same 11 keys appear in order; rk_data stays stable while valid & !ready; no drops or duplicates.
- mode = 11 start -> err pulse for 1 cycle, busy stays 0. Start during busy -> ignored; run output unchanged.
- abort at round 5 (AES-256) -> rk_valid = 0 and busy = 0 next cycle, no done. A new AES-128 run then matches the first scenario. rst_n asserted mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/aes_key_expand_iter.sv
// Iterative AES-128/192/256 key expander: one schedule word per clock,
// round keys streamed out over a valid/ready handshake.
module aes_key_expand_iter #(
  parameter int KEY_W   = 256,
  parameter int RKIDX_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [KEY_W-1:0]   key_in,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               rk_valid,
  input  logic               rk_ready,
  output logic [127:0]       rk_data,
  output logic [RKIDX_W-1:0] rk_round
);

  typedef enum logic [1:0] {IDLE, LOAD, GEN, DRAIN} state_e;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic [31:0]          hist_q [0:7];
  logic [31:0]          hist_d [0:7];
  logic [5:0]           i_q, i_d;
  logic [2:0]           j_q, j_d;
  logic [7:0]           rc_q, rc_d;
  logic [127:0]         asm_q, asm_d;
  logic [2:0]           asm_cnt_q, asm_cnt_d;
  logic                 rk_valid_q, rk_valid_d;
  logic [127:0]         rk_data_q, rk_data_d;
  logic [RKIDX_W-1:0]   rk_round_q, rk_round_d;
  logic [RKIDX_W-1:0]   rnd_next_q, rnd_next_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [2:0]           nk_m1;
  logic [RKIDX_W-1:0]   nr;
  logic [5:0]           last_i;
  logic [31:0]          w_prev, w_back, sub_in, sub_out, temp, gen_word;
  logic                 out_free, gen_fire;

  always_comb begin
    nk_m1  = 3'd3;
    nr     = RKIDX_W'(10);
    last_i = 6'd43;
    case (mode_q)
      2'b01: begin nk_m1 = 3'd5; nr = RKIDX_W'(12); last_i = 6'd51; end
      2'b10: begin nk_m1 = 3'd7; nr = RKIDX_W'(14); last_i = 6'd59; end
      default: ;
    endcase
  end

  // hist_q[0] is w[i-1]; hist_q[Nk-1] is w[i-Nk]
  always_comb begin
    w_prev  = hist_q[0];
    w_back  = hist_q[nk_m1];
    sub_in  = (j_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = sub_word(sub_in);
    if (j_q == 3'd0)                         temp = sub_out ^ {rc_q, 24'h0};
    else if (nk_m1 == 3'd7 && j_q == 3'd4)   temp = sub_out;
    else                                     temp = w_prev;
    gen_word = (state_q == LOAD) ? key_q[KEY_W-1 -: 32] : (w_back ^ temp);
  end

  assign out_free = !rk_valid_q || rk_ready;
  assign gen_fire = (state_q == LOAD || state_q == GEN) &&
                    !(asm_cnt_q == 3'd4 && !out_free);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    key_d      = key_q;
    hist_d     = hist_q;
    i_d        = i_q;
    j_d        = j_q;
    rc_d       = rc_q;
    asm_d      = asm_q;
    asm_cnt_d  = asm_cnt_q;
    rk_valid_d = rk_valid_q && !rk_ready;
    rk_data_d  = rk_data_q;
    rk_round_d = rk_round_q;
    rnd_next_d = rnd_next_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    // A parked full key leaves first; a 4th fresh word can bypass assembly
    if (asm_cnt_q == 3'd4 && out_free) begin
      rk_valid_d = 1'b1;
      rk_data_d  = asm_q;
      rk_round_d = rnd_next_q;
      rnd_next_d = rnd_next_q + 1'b1;
      asm_cnt_d  = 3'd0;
    end

    if (gen_fire) begin
      if (asm_cnt_q == 3'd3 && out_free) begin
        rk_valid_d = 1'b1;
        rk_data_d  = {asm_q[95:0], gen_word};
        rk_round_d = rnd_next_q;
        rnd_next_d = rnd_next_q + 1'b1;
        asm_cnt_d  = 3'd0;
      end else begin
        asm_d     = {asm_q[95:0], gen_word};
        asm_cnt_d = (asm_cnt_q == 3'd4) ? 3'd1 : asm_cnt_q + 3'd1;
      end
      for (int k = 7; k > 0; k--) hist_d[k] = hist_q[k-1];
      hist_d[0] = gen_word;
      key_d     = key_q << 32;
      i_d       = i_q + 6'd1;
      j_d       = (j_q == nk_m1) ? 3'd0 : j_q + 3'd1;
      if (state_q == GEN && j_q == 3'd0)
        rc_d = {rc_q[6:0], 1'b0} ^ (rc_q[7] ? 8'h1b : 8'h00);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (mode == 2'b11) begin
            err_d = 1'b1;
          end else begin
            mode_d     = mode;
            key_d      = key_in;
            i_d        = 6'd0;
            j_d        = 3'd0;
            rc_d       = 8'h01;
            asm_cnt_d  = 3'd0;
            rnd_next_d = '0;
            busy_d     = 1'b1;
            state_d    = LOAD;
          end
        end
      end
      LOAD:  if (gen_fire && j_q == nk_m1) state_d = GEN;
      GEN:   if (gen_fire && i_q == last_i) state_d = DRAIN;
      DRAIN: begin
        if (rk_valid_q && rk_ready && rk_round_q == nr) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = IDLE;
      rk_valid_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      asm_cnt_d  = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= 2'b00;
      key_q      <= '0;
      for (int k = 0; k < 8; k++) hist_q[k] <= 32'h0;
      i_q        <= 6'd0;
      j_q        <= 3'd0;
      rc_q       <= 8'h00;
      asm_q      <= 128'h0;
      asm_cnt_q  <= 3'd0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= 128'h0;
      rk_round_q <= '0;
      rnd_next_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      key_q      <= key_d;
      hist_q     <= hist_d;
      i_q        <= i_d;
      j_q        <= j_d;
      rc_q       <= rc_d;
      asm_q      <= asm_d;
      asm_cnt_q  <= asm_cnt_d;
      rk_valid_q <= rk_valid_d;
      rk_data_q  <= rk_data_d;
      rk_round_q <= rk_round_d;
      rnd_next_q <= rnd_next_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign rk_round = rk_round_q;

endmodule

// File: tb/tb_aes_key_expand_iter.sv
// Directed bench for aes_key_expand_iter using FIPS-197 key schedules.
module tb_aes_key_expand_iter;

  logic         clk = 1'b0;
  logic         rst_n, start, abort, rk_ready;
  logic [1:0]   mode;
  logic [255:0] key_in;
  logic         busy, done, err, rk_valid;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;

  aes_key_expand_iter #(.KEY_W(256), .RKIDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key_in(key_in),
    .abort(abort), .busy(busy), .done(done), .err(err), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .rk_data(rk_data), .rk_round(rk_round)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeefcafef00d0123456789abcdef};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h5555aaaa5555aaaa};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    logic [1:0]   mode;
    logic [255:0] key;
    int           round;
    logic [127:0] expKey;
    int           expXfers;
  } vec_t;

  vec_t vecs [16];

  int           testsRun = 0;
  int           testsFailed = 0;
  logic [127:0] capKey [0:15];
  logic [3:0]   capRound [0:15];
  int           validCycle [0:15];
  int           nXfer, doneCycle;
  logic         stableOk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Start one expansion and follow it to done (or a cycle budget), recording
  // every transfer. Cycle 0 is the cycle right after start is accepted.
  task automatic applyStimulus(input logic [1:0] m, input logic [255:0] k,
                               input int readyPct, input int injectCycle);
    int           cyc;
    logic         hold;
    logic [127:0] hd;
    logic [3:0]   hr;
    nXfer = 0;
    doneCycle = -1;
    stableOk = 1'b1;
    for (int r = 0; r < 16; r++) validCycle[r] = -1;
    @(negedge clk);
    mode = m; key_in = k; start = 1'b1; rk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; mode = 2'b01; key_in = ~k;
    cyc = 0;
    hold = 1'b0;
    hd = '0;
    hr = '0;
    while (cyc < 600) begin
      if (done) begin
        doneCycle = cyc;
        break;
      end
      if (hold && (!rk_valid || rk_data !== hd || rk_round !== hr)) stableOk = 1'b0;
      if (rk_valid && validCycle[rk_round] < 0) validCycle[rk_round] = cyc;
      start = (cyc == injectCycle);
      if (start) begin
        mode = 2'b00;
        key_in = K256;
      end
      rk_ready = (readyPct >= 100) ? 1'b1 : ($urandom_range(0, 99) < readyPct);
      if (rk_valid && rk_ready && nXfer < 16) begin
        capKey[nXfer] = rk_data;
        capRound[nXfer] = rk_round;
        nXfer++;
      end
      hold = rk_valid && !rk_ready;
      hd = rk_data;
      hr = rk_round;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    rk_ready = 1'b0;
    checkOutput("run reached done", 128'(doneCycle >= 0), 128'd1);
  endtask

  initial begin
    int   found;
    logic sawDone;

    vecs[0]  = '{2'b00, K128, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 11};
    vecs[1]  = '{2'b00, K128, 1,  128'ha0fafe1788542cb123a339392a6c7605, 11};
    vecs[2]  = '{2'b00, K128, 2,  128'hf2c295f27a96b9435935807a7359f67f, 11};
    vecs[3]  = '{2'b00, K128, 3,  128'h3d80477d4716fe3e1e237e446d7a883b, 11};
    vecs[4]  = '{2'b00, K128, 4,  128'hef44a541a8525b7fb671253bdb0bad00, 11};
    vecs[5]  = '{2'b00, K128, 5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc, 11};
    vecs[6]  = '{2'b00, K128, 6,  128'h6d88a37a110b3efddbf98641ca0093fd, 11};
    vecs[7]  = '{2'b00, K128, 7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 11};
    vecs[8]  = '{2'b00, K128, 8,  128'head27321b58dbad2312bf5607f8d292f, 11};
    vecs[9]  = '{2'b00, K128, 9,  128'hac7766f319fadc2128d12941575c006e, 11};
    vecs[10] = '{2'b00, K128, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 11};
    vecs[11] = '{2'b01, K192, 0,  128'h8e73b0f7da0e6452c810f32b809079e5, 13};
    vecs[12] = '{2'b01, K192, 12, 128'he98ba06f448c773c8ecc720401002202, 13};
    vecs[13] = '{2'b10, K256, 0,  128'h603deb1015ca71be2b73aef0857d7781, 15};
    vecs[14] = '{2'b10, K256, 1,  128'h1f352c073b6108d72d9810a30914dff4, 15};
    vecs[15] = '{2'b10, K256, 14, 128'hfe4890d1e6188d0b046df344706c631e, 15};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rk_ready = 1'b0;
    mode = 2'b00; key_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset rk_data", rk_data, 128'h0);
    checkOutput("reset flags", 128'({busy, done, err, rk_valid, rk_round}), 128'h0);
    rst_n = 1'b1;

    for (int v = 0; v < 16; v++) begin
      applyStimulus(vecs[v].mode, vecs[v].key, 100, -1);
      checkOutput($sformatf("vec%0d rk_data r%0d", v, vecs[v].round), capKey[vecs[v].round], vecs[v].expKey);
      checkOutput($sformatf("vec%0d rk_round", v), 128'(capRound[vecs[v].round]), 128'(vecs[v].round));
      checkOutput($sformatf("vec%0d transfers", v), 128'(nXfer), 128'(vecs[v].expXfers));
    end

    // Latency and done timing with rk_ready held high
    applyStimulus(2'b00, K128, 100, -1);
    checkOutput("r0 valid cycle", 128'(validCycle[0]), 128'd4);
    checkOutput("r10 valid cycle", 128'(validCycle[10]), 128'd44);
    checkOutput("done cycle", 128'(doneCycle), 128'd45);
    checkOutput("busy clear at done", 128'(busy), 128'd0);
    @(negedge clk);
    checkOutput("done single pulse", 128'(done), 128'd0);

    // Randomly throttled consumer
    applyStimulus(2'b00, K128, 30, -1);
    checkOutput("random ready transfers", 128'(nXfer), 128'd11);
    checkOutput("random ready stable", 128'(stableOk), 128'd1);
    for (int r = 0; r < 11; r++) begin
      checkOutput($sformatf("random ready r%0d", r), capKey[r], vecs[r].expKey);
      checkOutput($sformatf("random ready round%0d", r), 128'(capRound[r]), 128'(r));
    end

    // Reserved mode
    @(negedge clk);
    mode = 2'b11; key_in = K256; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("err pulse", 128'(err), 128'd1);
    checkOutput("err busy", 128'(busy), 128'd0);
    @(negedge clk);
    checkOutput("err cleared", 128'(err), 128'd0);
    checkOutput("err stays idle", 128'(busy), 128'd0);

    // Start while busy must be ignored
    applyStimulus(2'b00, K128, 100, 20);
    checkOutput("start busy transfers", 128'(nXfer), 128'd11);
    checkOutput("start busy r10", capKey[10], vecs[10].expKey);
    checkOutput("start busy done cycle", 128'(doneCycle), 128'd45);

    // Abort on round 5 of an AES-256 run
    @(negedge clk);
    mode = 2'b10; key_in = K256; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rk_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      if (rk_valid && rk_round == 4'd5) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("abort reached round5", 128'(found), 128'd1);
    abort = 1'b1; rk_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort rk_valid", 128'(rk_valid), 128'd0);
    checkOutput("abort busy", 128'(busy), 128'd0);
    sawDone = 1'b0;
    rk_ready = 1'b1;
    repeat (60) begin
      if (done || rk_valid) sawDone = 1'b1;
      @(negedge clk);
    end
    rk_ready = 1'b0;
    checkOutput("abort no done", 128'(sawDone), 128'd0);

    applyStimulus(2'b00, K128, 100, -1);
    checkOutput("post abort r0", capKey[0], vecs[0].expKey);
    checkOutput("post abort r10", capKey[10], vecs[10].expKey);
    checkOutput("post abort done cycle", 128'(doneCycle), 128'd45);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    mode = 2'b00; key_in = K128; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rk_ready = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("pre reset valid", 128'(rk_valid), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid reset rk_data", rk_data, 128'h0);
    checkOutput("mid reset flags", 128'({busy, done, err, rk_valid, rk_round}), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
